main: RTL and testbench
=======================

Name: main

Overview:
- Top-level out-of-order core using Tomasulo scheduling with in-order commit.
- Fetches 16-bit instructions from an internal 16-entry instruction memory into a 4-entry instruction queue (IQ), then dispatches them.
- Arithmetic instructions go to two reservation stations. Results broadcast on a single common data bus (CDB). An 8-entry reorder buffer (ROB) retires results into a 16x8 register file and a 16-byte data memory.

Parameters:
- None. All sizes are fixed: IQ 4, ROB 8, each RS 4, registers 16x8b, imem 16x16b, dmem 16x8b.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  4  start fetch address, latched on the first clk edge after rst_n deasserts.
- imem_we  in  1  program-load write enable; honoured only while halted or before start.
- imem_waddr  in  4  program-load address.
- imem_wdata  in  16  program-load data.
- dbg_raddr  in  4  debug register-read address.
- dbg_rdata  out  8  combinational read of the architectural register file.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- commit_opcode  out  4  opcode of the retired instruction.
- commit_reg  out  4  destination register of the retired instruction (0 for store).
- commit_value  out  8  value written at retirement (store: data written).
- halted  out  1  high once HALT has retired and the pipeline is empty.

Behaviour:
- Encoding:
  - Arithmetic: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
  - Load/store: [15:12] op, [11:8] rs, [7:4] rb, [3:0] imm.
  - Effective address = (R[rb] + imm) mod 16.
- Opcodes:
  - 0000 sub, 0001 add, 0010 mul, 0011 div, 0100 store (M[ea] <= R[rs]), 0101 load (R[rs] <= M[ea]).
  - 1111 HALT. 0110-1110 are NOP; they take a ROB entry and write nothing.
- Arithmetic: 8-bit unsigned, wrap-around. mul keeps the low 8 bits. div is the unsigned quotient; divide by zero gives 8'hFF.
- Reset values:
  - R[i] = i; M[a] = 8'h10 + a.
  - IQ, ROB, RS and rename table empty/invalid.
  - All outputs 0; imem contents kept.
- Fetch:
  - One instruction per cycle into the IQ tail when the IQ is not full.
  - PC increments mod 16.
  - Fetch stops permanently after fetching HALT.
- Dispatch:
  - One per cycle from the IQ head. Requires a free ROB entry, plus a free entry in the target RS for arithmetic ops.
  - Stall if either is full; in-order, so no bypassing.
  - Source operands come from the register file if the rename entry is invalid. Otherwise from the ROB value if that entry is ready, otherwise the 3-bit ROB tag is recorded.
  - Destination: rename[rd] <= ROB tail tag.
- Reservation stations:
  - RS1 holds add/sub; RS2 holds mul/div.
  - An entry is ready when both operands are valid. The oldest ready entry issues to the station's single non-pipelined unit.
  - Latencies from issue to result available: add/sub 2 cycles, mul 6, div 8.
  - CDB snooping captures operands in the same cycle as the broadcast.
- CDB:
  - One broadcast per cycle carrying (ROB tag, value). The RS2 unit has priority over RS1.
  - A losing unit holds its result and stalls until granted.
- Load/store:
  - Executes only when at the ROB head with its operands ready.
  - Fixed 4-cycle memory operation.
  - Store writes memory at commit.
- Commit:
  - One per cycle from the ROB head when its entry is ready.
  - Writes the register file, pulses commit_* outputs, and clears rename[rd] only if it still holds the head tag.
  - Head and tail wrap mod 8. Full/empty are distinguished by an occupancy count.
- Halt: halted asserts the cycle after HALT commits. commit_valid pulses for HALT with commit_reg = 0.
- Simultaneous events: commit and dispatch in the same cycle to the same register leave rename pointing at the new tag. CDB write and commit of a different entry in the same cycle are both honoured.
- Reset mid-operation: all in-flight state is discarded immediately.

Decomposition:
- Shared package: opcode constants, widths (REG_W=8, TAG_W=3), and a ROB entry struct (opcode, dest, value, ready).
- One natural sub-module: main_exec_unit, a parameterised-latency non-pipelined ALU (add/sub, or mul/div), instanced twice.

Test Plan:
1. add r3,r1,r2 (16'h1312) then HALT (16'hF000), pc=0 -> commit r3=8'h03, then halted=1.
2. sub r4,r1,r2 (16'h0412) -> commit r4=8'hFF (wrap).
3. mul r5,r2,r3 (16'h2523); add r6,r5,r1 (16'h1651) -> r5=06 retires before r6=07; add waits on tag via CDB.
4. div r7,r1,r0 (16'h3710); div r8,r9,r2 (16'h3892) -> r7=FF, r8=04; the add following both commits last despite finishing first.
5. store r9,[r2+1] (16'h4921); load r10,[r1+2] (16'h5A12) -> M[3]=09, r10=09.
6. Reset asserted mid-run during a div -> outputs 0, no further commits, dbg_rdata for r8 = 8'h08; restart from pc=4 fetches imem[4] first.

Source files
------------

// File: rtl/main_pkg.sv
// Shared types, opcodes and ALU helper for the out-of-order core.
// Imported by the core top and its execution units.
package main_pkg;

    localparam int REG_W = 8;
    localparam int TAG_W = 3;

    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [3:0]       dest;
        logic [REG_W-1:0] value;
        logic             ready;
    } rob_entry_t;

    typedef struct packed {
        logic             valid;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic             rdy1;
        logic [TAG_W-1:0] q1;
        logic [REG_W-1:0] v1;
        logic             rdy2;
        logic [TAG_W-1:0] q2;
        logic [REG_W-1:0] v2;
    } rs_entry_t;

    function automatic logic has_dest(input logic [3:0] op);
        return (op[3:2] == 2'b00) || (op == OP_LD);
    endfunction

    function automatic logic [REG_W-1:0] alu(input logic [1:0] op, input logic [REG_W-1:0] a,
                                             input logic [REG_W-1:0] b);
        logic [2*REG_W-1:0] prod;
        prod = {{REG_W{1'b0}}, a} * {{REG_W{1'b0}}, b};
        case (op)
            2'd0:    return a - b;
            2'd1:    return a + b;
            2'd2:    return prod[REG_W-1:0];
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

endpackage

// File: rtl/main_exec_unit.sv
// Non-pipelined functional unit with per-op latency; holds its result until granted the CDB.
// op[0] selects the odd-opcode latency (add or div).
module main_exec_unit
    import main_pkg::*;
#(
    parameter int unsigned LAT_EVEN = 2,
    parameter int unsigned LAT_ODD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [REG_W-1:0] a,
    input  logic [REG_W-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             grant,
    output logic             busy,
    output logic             done,
    output logic [TAG_W-1:0] tag,
    output logic [REG_W-1:0] value
);

    logic             busy_q;
    logic [3:0]       cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic [REG_W-1:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tag_q   <= '0;
            value_q <= '0;
        end else if (!busy_q) begin
            if (start) begin
                busy_q  <= 1'b1;
                cnt_q   <= 4'(op[0] ? LAT_ODD - 1 : LAT_EVEN - 1);
                tag_q   <= tag_in;
                value_q <= alu(op, a, b);
            end
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end else if (grant) begin
            busy_q <= 1'b0;
        end
    end

    assign busy  = busy_q;
    assign done  = busy_q && (cnt_q == 4'd0);
    assign tag   = tag_q;
    assign value = value_q;

endmodule

// File: rtl/main.sv
// Tomasulo core: fetch -> 4-entry IQ -> dispatch to two RS / ROB, single CDB, in-order commit.
// Loads and stores execute at the ROB head, so they read the architectural register file directly.
module main
    import main_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       pc,
    input  logic             imem_we,
    input  logic [3:0]       imem_waddr,
    input  logic [15:0]      imem_wdata,
    input  logic [3:0]       dbg_raddr,
    output logic [REG_W-1:0] dbg_rdata,
    output logic             commit_valid,
    output logic [3:0]       commit_opcode,
    output logic [3:0]       commit_reg,
    output logic [REG_W-1:0] commit_value,
    output logic             halted
);

    logic [15:0]      imem_q [16];
    logic             started_q, fetch_stop_q, halted_q;
    logic [3:0]       fpc_q;
    logic [15:0]      iq_q [4];
    logic [1:0]       iq_head_q, iq_tail_q;
    logic [2:0]       iq_cnt_q;
    rob_entry_t       rob_q [8];
    logic [TAG_W-1:0] rob_head_q, rob_tail_q;
    logic [3:0]       rob_cnt_q;
    logic             ren_valid_q [16];
    logic [TAG_W-1:0] ren_tag_q [16];
    logic [REG_W-1:0] rf_q [16];
    logic [REG_W-1:0] dmem_q [16];
    rs_entry_t        rs_q [2][4];
    logic             lsu_busy_q;
    logic [1:0]       lsu_cnt_q;
    logic [3:0]       lsu_ea_q;
    logic [REG_W-1:0] lsu_data_q;
    logic             cv_q;
    logic [3:0]       cop_q, creg_q;
    logic [REG_W-1:0] cval_q;

    always_ff @(posedge clk) begin
        if (imem_we && (!started_q || halted_q)) imem_q[imem_waddr] <= imem_wdata;
    end

    // Dispatch decode
    logic [15:0] d_instr;
    logic [3:0]  d_op, d_rd;
    logic        d_arith, d_ls, d_stn, fetch, dispatch;
    assign d_instr = iq_q[iq_head_q];
    assign d_op    = d_instr[15:12];
    assign d_rd    = d_instr[11:8];
    assign d_arith = (d_op[3:2] == 2'b00);
    assign d_ls    = (d_op == OP_ST) || (d_op == OP_LD);
    assign d_stn   = d_op[1];
    assign fetch   = started_q && !fetch_stop_q && (iq_cnt_q != 3'd4);

    // CDB and execution units
    logic             u_busy [2], u_done [2], u_grant [2];
    logic [TAG_W-1:0] u_tag [2];
    logic [REG_W-1:0] u_val [2];
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [REG_W-1:0] cdb_value;
    assign u_grant[1] = u_done[1];
    assign u_grant[0] = u_done[0] && !u_done[1];
    assign cdb_valid  = u_done[0] || u_done[1];
    assign cdb_tag    = u_done[1] ? u_tag[1] : u_tag[0];
    assign cdb_value  = u_done[1] ? u_val[1] : u_val[0];

    // RS free-slot and oldest-ready selection; age is distance from the ROB head
    logic [1:0] free_idx [2], iss_idx [2];
    logic       has_free [2], iss_en [2];
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            logic [TAG_W-1:0] age, best;
            logic found;
            has_free[s] = 1'b0;
            free_idx[s] = '0;
            iss_idx[s]  = '0;
            found       = 1'b0;
            best        = '0;
            for (int i = 3; i >= 0; i--) begin
                if (!rs_q[s][i].valid) begin
                    has_free[s] = 1'b1;
                    free_idx[s] = 2'(i);
                end
            end
            for (int i = 0; i < 4; i++) begin
                age = rs_q[s][i].tag - rob_head_q;
                if (rs_q[s][i].valid && rs_q[s][i].rdy1 && rs_q[s][i].rdy2 && (!found || age < best)) begin
                    found      = 1'b1;
                    best       = age;
                    iss_idx[s] = 2'(i);
                end
            end
            iss_en[s] = found && !u_busy[s];
        end
    end

    assign dispatch = (iq_cnt_q != 3'd0) && (rob_cnt_q != 4'd8) && (!d_arith || has_free[d_stn]);

    // Source operand lookup: RF, then ROB value, then same-cycle CDB, else wait on tag
    logic             src_rdy [2];
    logic [TAG_W-1:0] src_tag [2];
    logic [REG_W-1:0] src_val [2];
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            logic [3:0] r;
            r          = (k == 0) ? d_instr[7:4] : d_instr[3:0];
            src_rdy[k] = 1'b1;
            src_tag[k] = ren_tag_q[r];
            src_val[k] = rf_q[r];
            if (ren_valid_q[r]) begin
                if (rob_q[ren_tag_q[r]].ready) begin
                    src_val[k] = rob_q[ren_tag_q[r]].value;
                end else if (cdb_valid && cdb_tag == ren_tag_q[r]) begin
                    src_val[k] = cdb_value;
                end else begin
                    src_rdy[k] = 1'b0;
                end
            end
        end
    end

    main_exec_unit #(.LAT_EVEN(2), .LAT_ODD(2)) u_addsub (
        .clk(clk), .rst_n(rst_n), .start(iss_en[0]), .op(rs_q[0][iss_idx[0]].op),
        .a(rs_q[0][iss_idx[0]].v1), .b(rs_q[0][iss_idx[0]].v2), .tag_in(rs_q[0][iss_idx[0]].tag),
        .grant(u_grant[0]), .busy(u_busy[0]), .done(u_done[0]), .tag(u_tag[0]), .value(u_val[0])
    );

    main_exec_unit #(.LAT_EVEN(6), .LAT_ODD(8)) u_muldiv (
        .clk(clk), .rst_n(rst_n), .start(iss_en[1]), .op(rs_q[1][iss_idx[1]].op),
        .a(rs_q[1][iss_idx[1]].v1), .b(rs_q[1][iss_idx[1]].v2), .tag_in(rs_q[1][iss_idx[1]].tag),
        .grant(u_grant[1]), .busy(u_busy[1]), .done(u_done[1]), .tag(u_tag[1]), .value(u_val[1])
    );

    // Head / commit; ld/st carry {rb, imm} in value until their memory op completes
    rob_entry_t       head;
    logic             do_commit, head_ls, lsu_start;
    logic [REG_W-1:0] lsu_sum;
    assign head      = rob_q[rob_head_q];
    assign do_commit = (rob_cnt_q != 4'd0) && head.ready;
    assign head_ls   = (head.opcode == OP_ST) || (head.opcode == OP_LD);
    assign lsu_start = (rob_cnt_q != 4'd0) && head_ls && !head.ready && !lsu_busy_q;
    assign lsu_sum   = rf_q[head.value[7:4]] + {4'b0, head.value[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q    <= 1'b0;
            fetch_stop_q <= 1'b0;
            halted_q     <= 1'b0;
            fpc_q        <= '0;
            iq_head_q    <= '0;
            iq_tail_q    <= '0;
            iq_cnt_q     <= '0;
            rob_head_q   <= '0;
            rob_tail_q   <= '0;
            rob_cnt_q    <= '0;
            lsu_busy_q   <= 1'b0;
            lsu_cnt_q    <= '0;
            lsu_ea_q     <= '0;
            lsu_data_q   <= '0;
            cv_q         <= 1'b0;
            cop_q        <= '0;
            creg_q       <= '0;
            cval_q       <= '0;
            for (int i = 0; i < 4; i++) iq_q[i] <= '0;
            for (int i = 0; i < 8; i++) rob_q[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                ren_valid_q[i] <= 1'b0;
                ren_tag_q[i]   <= '0;
                rf_q[i]        <= 8'(i);
                dmem_q[i]      <= 8'(8'h10 + i);
            end
        end else begin
            cv_q <= 1'b0;
            if (!started_q) begin
                started_q <= 1'b1;
                fpc_q     <= pc;
            end
            if (fetch) begin
                iq_q[iq_tail_q] <= imem_q[fpc_q];
                iq_tail_q       <= iq_tail_q + 2'd1;
                fpc_q           <= fpc_q + 4'd1;
                if (imem_q[fpc_q][15:12] == OP_HALT) fetch_stop_q <= 1'b1;
            end
            if (dispatch) iq_head_q <= iq_head_q + 2'd1;
            iq_cnt_q <= iq_cnt_q + {2'b0, fetch} - {2'b0, dispatch};

            if (cdb_valid) begin
                rob_q[cdb_tag].value <= cdb_value;
                rob_q[cdb_tag].ready <= 1'b1;
            end

            if (lsu_start) begin
                lsu_busy_q <= 1'b1;
                lsu_cnt_q  <= 2'd3;
                lsu_ea_q   <= lsu_sum[3:0];
                lsu_data_q <= rf_q[head.dest];
            end else if (lsu_busy_q) begin
                if (lsu_cnt_q != 2'd0) begin
                    lsu_cnt_q <= lsu_cnt_q - 2'd1;
                end else begin
                    lsu_busy_q                <= 1'b0;
                    rob_q[rob_head_q].value <= (head.opcode == OP_LD) ? dmem_q[lsu_ea_q] : lsu_data_q;
                    rob_q[rob_head_q].ready <= 1'b1;
                end
            end

            if (do_commit) begin
                rob_head_q <= rob_head_q + 3'd1;
                cv_q       <= 1'b1;
                cop_q      <= head.opcode;
                creg_q     <= has_dest(head.opcode) ? head.dest : 4'd0;
                cval_q     <= (has_dest(head.opcode) || head.opcode == OP_ST) ? head.value : '0;
                if (has_dest(head.opcode)) begin
                    rf_q[head.dest] <= head.value;
                    if (ren_tag_q[head.dest] == rob_head_q) ren_valid_q[head.dest] <= 1'b0;
                end
                if (head.opcode == OP_ST) dmem_q[lsu_ea_q] <= head.value;
                if (head.opcode == OP_HALT) halted_q <= 1'b1;
            end

            // Placed after commit so a same-register dispatch keeps the new tag
            if (dispatch) begin
                rob_q[rob_tail_q] <= '{opcode: d_op, dest: d_rd,
                                       value: d_ls ? d_instr[7:0] : 8'h00,
                                       ready: !(d_arith || d_ls)};
                rob_tail_q <= rob_tail_q + 3'd1;
                if (has_dest(d_op)) begin
                    ren_valid_q[d_rd] <= 1'b1;
                    ren_tag_q[d_rd]   <= rob_tail_q;
                end
            end
            rob_cnt_q <= rob_cnt_q + {3'b0, dispatch} - {3'b0, do_commit};
        end
    end

    // Reservation stations: CDB and commit snooping, issue, fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < 4; i++) rs_q[s][i] <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 4; i++) begin
                    if (rs_q[s][i].valid && !rs_q[s][i].rdy1) begin
                        if (cdb_valid && rs_q[s][i].q1 == cdb_tag) begin
                            rs_q[s][i].v1   <= cdb_value;
                            rs_q[s][i].rdy1 <= 1'b1;
                        end else if (do_commit && rs_q[s][i].q1 == rob_head_q) begin
                            rs_q[s][i].v1   <= head.value;
                            rs_q[s][i].rdy1 <= 1'b1;
                        end
                    end
                    if (rs_q[s][i].valid && !rs_q[s][i].rdy2) begin
                        if (cdb_valid && rs_q[s][i].q2 == cdb_tag) begin
                            rs_q[s][i].v2   <= cdb_value;
                            rs_q[s][i].rdy2 <= 1'b1;
                        end else if (do_commit && rs_q[s][i].q2 == rob_head_q) begin
                            rs_q[s][i].v2   <= head.value;
                            rs_q[s][i].rdy2 <= 1'b1;
                        end
                    end
                    if (iss_en[s] && iss_idx[s] == 2'(i)) rs_q[s][i].valid <= 1'b0;
                    if (dispatch && d_arith && d_stn == 1'(s) && free_idx[s] == 2'(i)) begin
                        rs_q[s][i] <= '{valid: 1'b1, op: d_op[1:0], tag: rob_tail_q,
                                        rdy1: src_rdy[0], q1: src_tag[0], v1: src_val[0],
                                        rdy2: src_rdy[1], q2: src_tag[1], v2: src_val[1]};
                    end
                end
            end
        end
    end

    assign dbg_rdata     = rf_q[dbg_raddr];
    assign commit_valid  = cv_q;
    assign commit_opcode = cop_q;
    assign commit_reg    = creg_q;
    assign commit_value  = cval_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_main.sv
// Directed bench for the Tomasulo core: expected retirements are queued per program and
// popped as commit_valid pulses arrive; register state is checked through the debug port.
module tb_main;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pc = '0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic [3:0]  dbg_raddr = '0;
    logic [7:0]  dbg_rdata;
    logic        commit_valid;
    logic [3:0]  commit_opcode;
    logic [3:0]  commit_reg;
    logic [7:0]  commit_value;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q [$];

    main dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .commit_valid(commit_valid), .commit_opcode(commit_opcode), .commit_reg(commit_reg),
        .commit_value(commit_value), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] w);
        imem_waddr = a;
        imem_wdata = w;
        imem_we    = 1'b1;
        @(negedge clk);
        imem_we    = 1'b0;
    endtask

    task automatic expect_commit(input logic [3:0] op, input logic [3:0] rg, input logic [7:0] v);
        exp_q.push_back({op, rg, v});
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic start(input logic [3:0] p);
        @(negedge clk);
        pc    = p;
        rst_n = 1'b1;
    endtask

    task automatic run(input int budget, input bit to_halt);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (commit_valid) begin
                if (exp_q.size() == 0) check("spurious_commit", {31'b0, commit_valid}, 32'h0);
                else check("commit", {16'b0, commit_opcode, commit_reg, commit_value}, {16'b0, exp_q.pop_front()});
            end
            if (to_halt && halted) done = 1'b1;
        end
        if (to_halt) check("halt_reached", {31'b0, halted}, 32'h1);
        check("commits_pending", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic dbg(input string tag, input logic [3:0] r, input logic [7:0] v);
        dbg_raddr = r;
        #1;
        check(tag, {24'b0, dbg_rdata}, {24'b0, v});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {14'b0, commit_valid, commit_opcode, commit_reg, commit_value, halted}, 32'h0);
        dbg("reset_r5", 4'd5, 8'h05);

        // add r3,r1,r2 ; halt
        load(4'd0, 16'h1312);
        load(4'd1, 16'hF000);
        expect_commit(4'h1, 4'd3, 8'h03);
        expect_commit(4'hF, 4'd0, 8'h00);
        start(4'd0);
        run(100, 1'b1);
        dbg("add_r3", 4'd3, 8'h03);

        // sub wraps
        enter_reset();
        load(4'd0, 16'h0412);
        load(4'd1, 16'hF000);
        expect_commit(4'h0, 4'd4, 8'hFF);
        expect_commit(4'hF, 4'd0, 8'h00);
        start(4'd0);
        run(100, 1'b1);
        dbg("sub_r4", 4'd4, 8'hFF);

        // mul then dependent add through the CDB
        enter_reset();
        load(4'd0, 16'h2523);
        load(4'd1, 16'h1651);
        load(4'd2, 16'hF000);
        expect_commit(4'h2, 4'd5, 8'h06);
        expect_commit(4'h1, 4'd6, 8'h07);
        expect_commit(4'hF, 4'd0, 8'h00);
        start(4'd0);
        run(100, 1'b1);
        dbg("mul_add_r6", 4'd6, 8'h07);

        // two divs (one by zero) then an independent add that finishes first but retires last
        enter_reset();
        load(4'd0, 16'h3710);
        load(4'd1, 16'h3892);
        load(4'd2, 16'h1B12);
        load(4'd3, 16'hF000);
        expect_commit(4'h3, 4'd7, 8'hFF);
        expect_commit(4'h3, 4'd8, 8'h04);
        expect_commit(4'h1, 4'd11, 8'h03);
        expect_commit(4'hF, 4'd0, 8'h00);
        start(4'd0);
        run(200, 1'b1);
        dbg("div0_r7", 4'd7, 8'hFF);
        dbg("div_r8", 4'd8, 8'h04);

        // store r9 -> M[3], then load it back into r10
        enter_reset();
        load(4'd0, 16'h4921);
        load(4'd1, 16'h5A12);
        load(4'd2, 16'hF000);
        expect_commit(4'h4, 4'd0, 8'h09);
        expect_commit(4'h5, 4'd10, 8'h09);
        expect_commit(4'hF, 4'd0, 8'h00);
        start(4'd0);
        run(200, 1'b1);
        dbg("load_r10", 4'd10, 8'h09);

        // reset during a div, then restart at pc=4
        enter_reset();
        load(4'd0, 16'h3892);
        load(4'd1, 16'hF000);
        load(4'd4, 16'h1C12);
        load(4'd5, 16'hF000);
        start(4'd0);
        run(8, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {14'b0, commit_valid, commit_opcode, commit_reg, commit_value, halted}, 32'h0);
        dbg("midreset_r8", 4'd8, 8'h08);
        run(3, 1'b0);
        expect_commit(4'h1, 4'd12, 8'h03);
        expect_commit(4'hF, 4'd0, 8'h00);
        start(4'd4);
        run(100, 1'b1);
        dbg("restart_r12", 4'd12, 8'h03);
        dbg("restart_r8", 4'd8, 8'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
